// File: rtl/m_io_select_responder.sv
// I/O select responder: decodes a fixed 7-bit I/O address, inserts WAIT_STATES wait cycles
// on READY, then emits a one-cycle read/write strobe and holds CS_n until IORQ_n is released.
module m_io_select_responder #(
  parameter logic [6:0]  MATCH_ADDR  = 7'h7F,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic       MasterClock,
  input  logic       Reset,
  input  logic [6:0] Addr,
  input  logic       IORQ_n,
  input  logic       RD_n,
  input  logic       WR_n,
  output logic       CS_n,
  output logic       READY,
  output logic       RdPulse,
  output logic       WrPulse,
  output logic       Abort
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);
  localparam bit         NoWait   = (WAIT_STATES == 0);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dir_wr_q, dir_wr_d;
  logic       cs_n_q, cs_n_d;
  logic       ready_q, ready_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       abort_q, abort_d;

  logic addr_hit;
  logic req;

  // AND-tree over bitwise equality with the match pattern
  assign addr_hit = &(~(Addr ^ MATCH_ADDR));
  // Exactly one strobe low; both low is treated as no request
  assign req      = ~IORQ_n & addr_hit & (RD_n ^ WR_n);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_wr_d = dir_wr_q;
    cs_n_d   = cs_n_q;
    ready_d  = ready_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    abort_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          cs_n_d   = 1'b0;
          dir_wr_d = ~WR_n;
          if (NoWait) begin
            state_d = StHold;
            rd_d    = WR_n;
            wr_d    = ~WR_n;
          end else begin
            state_d = StWait;
            ready_d = 1'b0;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (IORQ_n) begin
          state_d = StIdle;
          cs_n_d  = 1'b1;
          ready_d = 1'b1;
          abort_d = 1'b1;
        end else if (cnt_q == 4'd1) begin
          state_d = StHold;
          ready_d = 1'b1;
          rd_d    = ~dir_wr_q;
          wr_d    = dir_wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (IORQ_n) begin
          state_d = StIdle;
          cs_n_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cs_n_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      dir_wr_q <= 1'b0;
      cs_n_q   <= 1'b1;
      ready_q  <= 1'b1;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_wr_q <= dir_wr_d;
      cs_n_q   <= cs_n_d;
      ready_q  <= ready_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      abort_q  <= abort_d;
    end
  end

  assign CS_n    = cs_n_q;
  assign READY   = ready_q;
  assign RdPulse = rd_q;
  assign WrPulse = wr_q;
  assign Abort   = abort_q;

endmodule

// File: tb/tb_m_io_select_responder.sv
// Randomized bench for m_io_select_responder: four instances with different wait counts and
// match addresses; a transaction-level model predicts CS_n/READY per cycle and queues pulses.
module tb_m_io_select_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] addr [4];
  logic [3:0] iorq_n, rd_n, wr_n;
  logic [3:0] cs_n, ready, rdp, wrp, abt;

  always #5 clk = ~clk;

  m_io_select_responder #(.MATCH_ADDR(7'h7F), .WAIT_STATES(2)) u_d0 (
    .MasterClock(clk), .Reset(rst), .Addr(addr[0]), .IORQ_n(iorq_n[0]), .RD_n(rd_n[0]),
    .WR_n(wr_n[0]), .CS_n(cs_n[0]), .READY(ready[0]), .RdPulse(rdp[0]), .WrPulse(wrp[0]),
    .Abort(abt[0]));
  m_io_select_responder #(.MATCH_ADDR(7'h7F), .WAIT_STATES(0)) u_d1 (
    .MasterClock(clk), .Reset(rst), .Addr(addr[1]), .IORQ_n(iorq_n[1]), .RD_n(rd_n[1]),
    .WR_n(wr_n[1]), .CS_n(cs_n[1]), .READY(ready[1]), .RdPulse(rdp[1]), .WrPulse(wrp[1]),
    .Abort(abt[1]));
  m_io_select_responder #(.MATCH_ADDR(7'h2A), .WAIT_STATES(3)) u_d2 (
    .MasterClock(clk), .Reset(rst), .Addr(addr[2]), .IORQ_n(iorq_n[2]), .RD_n(rd_n[2]),
    .WR_n(wr_n[2]), .CS_n(cs_n[2]), .READY(ready[2]), .RdPulse(rdp[2]), .WrPulse(wrp[2]),
    .Abort(abt[2]));
  m_io_select_responder #(.MATCH_ADDR(7'h7F), .WAIT_STATES(5)) u_d3 (
    .MasterClock(clk), .Reset(rst), .Addr(addr[3]), .IORQ_n(iorq_n[3]), .RD_n(rd_n[3]),
    .WR_n(wr_n[3]), .CS_n(cs_n[3]), .READY(ready[3]), .RdPulse(rdp[3]), .WrPulse(wrp[3]),
    .Abort(abt[3]));

  // kind: 0 read pulse, 1 write pulse, 2 abort
  typedef struct {int dev; int kind; int edge_n;} ev_t;
  ev_t sb[$];

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic       mon_en = 1'b0;
  logic [3:0] exp_cs_n  = 4'hF;
  logic [3:0] exp_ready = 4'hF;

  function automatic logic [6:0] match_of(input int d);
    case (d)
      2:       return 7'h2A;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int ws_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_exp(input int d, input logic cs, input logic rdy);
    exp_cs_n     = 4'hF;
    exp_ready    = 4'hF;
    exp_cs_n[d]  = cs;
    exp_ready[d] = rdy;
  endtask

  task automatic idle_dev(input int d);
    iorq_n[d] = 1'b1;
    rd_n[d]   = 1'b1;
    wr_n[d]   = 1'b1;
    addr[d]   = 7'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      tick();
      exp_cs_n  = 4'hF;
      exp_ready = 4'hF;
    end
  endtask

  // One CPU I/O cycle on device d. abort_j = k releases IORQ_n for the k-th wait edge (0 = none).
  task automatic txn(input int d, input logic [6:0] a, input logic rdl, input logic wrl,
                     input int abort_j, input int hold);
    int w;
    bit req;
    int kind;
    w    = ws_of(d);
    req  = (a == match_of(d)) && (rdl != wrl);
    kind = wrl ? 1 : 0;
    addr[d] = a; iorq_n[d] = 1'b0; rd_n[d] = ~rdl; wr_n[d] = ~wrl;
    tick();
    if (!req) begin
      set_exp(d, 1'b1, 1'b1);
      repeat (hold) begin tick(); set_exp(d, 1'b1, 1'b1); end
      idle_dev(d);
      tick();
      set_exp(d, 1'b1, 1'b1);
      return;
    end
    if (w == 0) begin
      set_exp(d, 1'b0, 1'b1);
      sb.push_back('{d, kind, cyc});
    end else begin
      set_exp(d, 1'b0, 1'b0);
      for (int j = 1; j <= w; j++) begin
        // Address and strobes are don't-care while waiting
        addr[d] = 7'($urandom); rd_n[d] = 1'($urandom); wr_n[d] = 1'($urandom);
        if (j == abort_j) begin
          iorq_n[d] = 1'b1;
          tick();
          set_exp(d, 1'b1, 1'b1);
          sb.push_back('{d, 2, cyc});
          idle_dev(d);
          return;
        end
        tick();
        if (j == w) begin
          set_exp(d, 1'b0, 1'b1);
          sb.push_back('{d, kind, cyc});
        end else begin
          set_exp(d, 1'b0, 1'b0);
        end
      end
    end
    repeat (hold) begin
      addr[d] = 7'($urandom); rd_n[d] = 1'($urandom); wr_n[d] = 1'($urandom);
      tick();
      set_exp(d, 1'b0, 1'b1);
    end
    idle_dev(d);
    tick();
    set_exp(d, 1'b1, 1'b1);
  endtask

  ev_t ev;
  int  k;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("cs_n[%0d]", d), 32'(cs_n[d]), 32'(exp_cs_n[d]));
        chk($sformatf("ready[%0d]", d), 32'(ready[d]), 32'(exp_ready[d]));
        if (rdp[d] || wrp[d] || abt[d]) begin
          k = abt[d] ? 2 : (wrp[d] ? 1 : 0);
          chk($sformatf("pulse_onehot[%0d]", d), $countones({rdp[d], wrp[d], abt[d]}), 1);
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: dev %0d kind %0d at edge %0d, none required",
                     d, k, cyc);
          end else begin
            ev = sb.pop_front();
            chk("pulse_dev", d, ev.dev);
            chk("pulse_kind", k, ev.kind);
            chk("pulse_edge", cyc, ev.edge_n);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) idle_dev(d);
    repeat (2) @(negedge clk);
    chk("reset_cs_n", 32'(cs_n), 32'hF);
    chk("reset_ready", 32'(ready), 32'hF);
    chk("reset_pulses", 32'({rdp, wrp, abt}), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    txn(0, 7'h7F, 1'b1, 1'b0, 0, 2);   // read, two wait states
    gap(1);
    txn(1, 7'h7F, 1'b0, 1'b1, 0, 3);   // write, zero wait
    gap(1);
    txn(0, 7'h7E, 1'b1, 1'b0, 0, 2);   // address mismatch
    txn(0, 7'h7F, 1'b1, 1'b1, 0, 2);   // both strobes low
    txn(3, 7'h7F, 1'b1, 1'b0, 2, 0);   // abort while waiting
    gap(1);
    txn(0, 7'h7F, 1'b1, 1'b0, 0, 1);   // back-to-back reads
    txn(0, 7'h7F, 1'b1, 1'b0, 0, 1);
    gap(2);

    // Async reset in the middle of a wait sequence
    addr[2] = 7'h2A; iorq_n[2] = 1'b0; rd_n[2] = 1'b0; wr_n[2] = 1'b1;
    tick(); set_exp(2, 1'b0, 1'b0);
    tick(); set_exp(2, 1'b0, 1'b0);
    tick(); set_exp(2, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_cs_n", 32'(cs_n[2]), 32'h1);
    chk("async_rst_ready", 32'(ready[2]), 32'h1);
    chk("async_rst_pulse", 32'({rdp[2], wrp[2], abt[2]}), 32'h0);
    idle_dev(2);
    set_exp(2, 1'b1, 1'b1);
    #1 rst = 1'b0;
    gap(2);
    txn(2, 7'h2A, 1'b0, 1'b1, 0, 1);   // clean cycle after reset
    gap(1);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      int         d, w, ab, st;
      logic [6:0] a;
      logic       rl, wl;
      d  = int'($urandom_range(0, 3));
      w  = ws_of(d);
      a  = ($urandom_range(0, 1) == 1) ? match_of(d) : 7'($urandom);
      st = int'($urandom_range(0, 9));
      rl = (st < 4) || (st == 8);
      wl = (st >= 4 && st < 8) || (st == 8);
      ab = (w > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, w)) : 0;
      txn(d, a, rl, wl, ab, int'($urandom_range(0, 3)));
      gap(int'($urandom_range(0, 2)));
    end

    gap(3);
    chk("scoreboard_drained", sb.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/m_io_select_responder.md
Name: m_io_select_responder

Overview:
- Target-side responder for the Slipstream I/O decode path.
- Registers a 7-bit address match (all bits equal MATCH_ADDR, an AND-tree decode) qualified by the CPU I/O strobes.
- Drives an active-low chip select and a READY line that inserts a programmable number of wait states.
- Issues a one-cycle read or write pulse to the selected peripheral register, then holds the select until the CPU releases the cycle.

Parameters:
- MATCH_ADDR, 7'h7F, address pattern that selects this responder.
- WAIT_STATES, 2, wait cycles inserted before the access completes; legal range 0..15.

Ports:
- MasterClock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Addr  input  7  CPU I/O address, synchronous to MasterClock.
- IORQ_n  input  1  I/O request, active low, synchronous.
- RD_n  input  1  read strobe, active low, synchronous.
- WR_n  input  1  write strobe, active low, synchronous.
- CS_n  output  1  registered chip select to peripheral, active low.
- READY  output  1  to CPU; 0 = insert wait state.
- RdPulse  output  1  one-cycle read-complete strobe to peripheral.
- WrPulse  output  1  one-cycle write-complete strobe to peripheral.
- Abort  output  1  one-cycle pulse when a cycle is withdrawn during wait states.

Behaviour:
- Clock and reset: one clock (MasterClock); Reset is asynchronous and active-high.
- Outputs are registered throughout; no combinational path from inputs to outputs.
- Reset values: state IDLE, counter 0, CS_n=1, READY=1, RdPulse=0, WrPulse=0, Abort=0.
- Reset asserted mid-cycle returns everything to reset values immediately; no pulse is emitted.
- Request (evaluated each edge in IDLE): IORQ_n=0 AND Addr==MATCH_ADDR AND exactly one of RD_n/WR_n low.
  - Direction (read/write) is latched at that edge.
  - RD_n and WR_n both low counts as no request; stay IDLE with outputs unchanged.
- States: IDLE, WAIT, HOLD.
- IDLE -> on request at edge N:
  - CS_n<=0.
  - If WAIT_STATES=0: go HOLD; RdPulse or WrPulse<=1 (high in cycle N+1); READY stays 1.
  - Else: go WAIT; READY<=0; counter<=WAIT_STATES.
- WAIT (each edge):
  - If IORQ_n=1: go IDLE; CS_n<=1, READY<=1, Abort<=1 for one cycle, no Rd/WrPulse.
  - Else if counter==1: go HOLD; READY<=1; pulse for the latched direction <=1.
  - Else: counter<=counter-1.
  - Net effect: READY low for exactly WAIT_STATES cycles (N+1..N+WAIT_STATES); pulse in cycle N+WAIT_STATES+1.
- Address and strobe changes during WAIT are ignored except IORQ_n.
- HOLD:
  - Rd/WrPulse cleared after one cycle.
  - CS_n stays 0 and READY stays 1 while IORQ_n=0.
  - On IORQ_n=1: go IDLE with CS_n<=1.
  - A new request may be accepted no earlier than the edge after returning to IDLE, so back-to-back cycles always see CS_n high for at least one cycle.
- Pulses: Abort, RdPulse and WrPulse are mutually exclusive and never high for more than one cycle.
- Counter: 4 bits, decrements without wrap; it cannot reach 0 in WAIT.

Test Plan:
- Reset mid-WAIT: WAIT_STATES=3, assert Reset asynchronously at N+2 -> CS_n=1 and READY=1 without waiting for a clock edge; no pulse; next match starts a clean cycle.
- Read, defaults: MATCH_ADDR=7'h7F, WAIT_STATES=2. Addr=7'h7F, IORQ_n=0, RD_n=0 sampled at edge N ->
  - CS_n=0 from N+1;
  - READY=0 in N+1 and N+2;
  - RdPulse=1 only in N+3, WrPulse stays 0;
  - after IORQ_n=1 is sampled, CS_n=1 on the following edge.
- Write, zero wait: WAIT_STATES=0, Addr=7'h7F, WR_n=0 -> READY never low; WrPulse=1 in N+1 only; CS_n low until IORQ_n release.
- Mismatch and illegal strobes:
  - Addr=7'h7E -> no response; CS_n=1, READY=1 throughout.
  - Addr=7'h7F with RD_n=WR_n=0 -> no response.
- Abort: WAIT_STATES=5, IORQ_n deasserted at N+2 -> Abort=1 for one cycle; CS_n=1, READY=1 next edge; no Rd/WrPulse.
- Back-to-back: two reads with IORQ_n high for one cycle between them -> CS_n high at least one cycle between; exactly two RdPulses.
